hilo_muldiv: RTL and testbench

- Multi-cycle multiply/divide unit that owns the architectural HI/LO register pair.
- It is the writer side of the HI/LO read path: it executes MULT/MULTU/DIV/DIVU/MTHI/MTLO and presents the selected HI or LO value to the EX-stage write-back select as RHLOut.
- The pipeline controller uses busy/done to stall younger HI/LO consumers.

---
 rtl/hilo_muldiv.sv | 165 ++++++++++++++++
 tb/tb_hilo_muldiv.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// Sign-magnitude datapath: operands are latched as magnitudes, signs are restored in FIN.
module hilo_muldiv #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  input  logic        hilo_sel,
  output logic [31:0] RHLOut,
  output logic        busy,
  output logic        done
);

  localparam int CNT_MAX = (MUL_CYCLES > 32) ? MUL_CYCLES : 32;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   rem_q, rem_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          neg_q, neg_d, rneg_q, rneg_d;
  logic          div0_q, div0_d, is_div_q, is_div_d;
  logic          done_q, done_d;

  logic        is_signed;
  logic [31:0] abs_a, abs_b;
  logic [63:0] prod, prod_fix;
  logic [32:0] r_shift, diff;
  logic [31:0] quo_fix, rem_fix;

  assign is_signed = ~op[0];
  assign abs_a     = (is_signed && A[31]) ? (~A + 32'd1) : A;
  assign abs_b     = (is_signed && B[31]) ? (~B + 32'd1) : B;

  // a_q/b_q are stable through all of MUL, so the product is a multicycle path into FIN.
  assign prod     = {32'd0, a_q} * {32'd0, b_q};
  assign prod_fix = neg_q ? (~prod + 64'd1) : prod;

  // Restoring step: a_q doubles as the dividend shift-out / quotient shift-in register.
  assign r_shift = {rem_q, a_q[31]};
  assign diff    = r_shift - {1'b0, b_q};
  assign quo_fix = neg_q  ? (~a_q + 32'd1)   : a_q;
  assign rem_fix = rneg_q ? (~rem_q + 32'd1) : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    is_div_d = is_div_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            3'b000, 3'b001: begin
              a_d      = abs_a;
              b_d      = abs_b;
              neg_d    = is_signed & (A[31] ^ B[31]);
              cnt_d    = '0;
              is_div_d = 1'b0;
              state_d  = S_MUL;
            end
            3'b010, 3'b011: begin
              a_d      = abs_a;
              b_d      = abs_b;
              neg_d    = is_signed & (A[31] ^ B[31]);
              rneg_d   = is_signed & A[31];
              div0_d   = (B == 32'd0);
              rem_d    = '0;
              cnt_d    = '0;
              is_div_d = 1'b1;
              state_d  = S_DIV;
            end
            3'b100:  hi_d = A;
            3'b101:  lo_d = A;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(MUL_CYCLES - 1)) begin
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = diff[32] ? r_shift[31:0] : diff[31:0];
          a_d   = {a_q[30:0], ~diff[32]};
          if (cnt_q == CW'(31)) state_d = S_FIN;
          else                  cnt_d   = cnt_q + 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // Divide-by-zero: remainder already equals A, quotient forced to all ones.
            hi_d = rem_fix;
            lo_d = div0_q ? 32'hFFFF_FFFF : quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      is_div_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      is_div_q <= is_div_d;
      done_q   <= done_d;
    end
  end

  assign RHLOut = hilo_sel ? hi_q : lo_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: vector table of back-to-back ops plus
// hand-written MTHI/MTLO, flush, start-while-busy and reset sequences.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst_n, start, flush, hilo_sel;
  logic [2:0]  op;
  logic [31:0] A, B, RHLOut;
  logic        busy, done;

  hilo_muldiv #(.MUL_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .flush(flush), .hilo_sel(hilo_sel), .RHLOut(RHLOut), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    hilo_sel = 1'b1;
    #1 hi = RHLOut;
    hilo_sel = 1'b0;
    #1 lo = RHLOut;
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int lat);
    int bad_busy, bad_done;
    logic [31:0] hi, lo;
    bad_busy = 0;
    bad_done = 0;
    exp_q.push_back(ehi);
    exp_q.push_back(elo);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < lat; c++) begin
      if (!busy) bad_busy++;
      if (done)  bad_done++;
      @(negedge clk);
    end
    check({name, "_busy_window"}, 32'(bad_busy), 32'd0);
    check({name, "_early_done"}, 32'(bad_done), 32'd0);
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    read_hilo(hi, lo);
    check({name, "_hi"}, hi, exp_q.pop_front());
    check({name, "_lo"}, lo, exp_q.pop_front());
  endtask

  vec_t vecs[9];
  logic [31:0] hi, lo;
  int done_seen;

  initial begin
    vecs[0] = '{3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 6};
    vecs[1] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 6};
    vecs[2] = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    vecs[3] = '{3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 34};
    vecs[4] = '{3'b011, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 34};
    vecs[5] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34};
    vecs[6] = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 34};
    vecs[7] = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 6};
    vecs[8] = '{3'b010, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 34};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; hilo_sel = 1'b0;
    op = 3'b000; A = '0; B = '0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    read_hilo(hi, lo);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Each op starts in the done cycle of the previous one.
    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].lat);

    // MTHI: same-cycle read returns old HI, new value visible next cycle.
    hilo_sel = 1'b1; op = 3'b100; A = 32'h0000_1234; start = 1'b1;
    #1 check("mthi_old", RHLOut, 32'h0000_0002);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    #1 check("mthi_new", RHLOut, 32'h0000_1234);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_done", {31'd0, done}, 32'd0);
    op = 3'b101; A = 32'h0000_5678; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; hilo_sel = 1'b0;
    #1 check("mtlo_new", RHLOut, 32'h0000_5678);
    check("mtlo_busy", {31'd0, busy}, 32'd0);

    // DIV with an ignored MULT at cycle 5 and a flush at cycle 10.
    op = 3'b010; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    op = 3'b000; A = 32'd3; B = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_flush_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("flush_no_done", 32'(done_seen), 32'd0);
    read_hilo(hi, lo);
    check("flush_hi", hi, 32'h0000_1234);
    check("flush_lo", lo, 32'h0000_5678);

    // Flush during FIN of a MULT suppresses the write.
    op = 3'b000; A = 32'd3; B = 32'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("fin_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("finflush_done", {31'd0, done}, 32'd0);
    check("finflush_busy", {31'd0, busy}, 32'd0);
    read_hilo(hi, lo);
    check("finflush_hi", hi, 32'h0000_1234);
    check("finflush_lo", lo, 32'h0000_5678);
    @(negedge clk);
    check("finflush_done_late", {31'd0, done}, 32'd0);

    // Asynchronous reset at cycle 20 of a DIV.
    op = 3'b010; A = 32'hFFFF_FFF9; B = 32'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1 check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    read_hilo(hi, lo);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("post_rst_mult", 3'b000, 32'd2, 32'd3, 32'd0, 32'd6, 6);
    run_op("b2b_multu", 3'b001, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
